// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR coefficient loader.
// FIR_COEF_SYMMETRIC_EN selects linear-phase mode: half-length sets with mirrored reads.
package fir_pkg;

    localparam int DATA_WIDTH_DEF = 24;
    localparam int FIR_DEPTH_DEF  = 16;
    localparam int ADDR_WIDTH_DEF = $clog2(FIR_DEPTH_DEF);

    function automatic int set_len(input int depth);
`ifdef FIR_COEF_SYMMETRIC_EN
        return depth / 2;
`else
        return depth;
`endif
    endfunction

    localparam int SET_LEN_DEF = set_len(FIR_DEPTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_PENDING
    } ld_state_e;

endpackage

// File: rtl/fir_coeff_bank.sv
// Two-bank simple dual-port coefficient memory; bank bit is the address MSB.
// Registered read output holds when not enabled.
module fir_coeff_bank #(
    parameter  int DATA_WIDTH = 24,
    parameter  int WORDS      = 16,
    localparam int AW         = $clog2(WORDS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_bank,
    input  logic [AW-1:0]         iv_wr_addr,
    input  logic [DATA_WIDTH-1:0] iv_wr_data,
    input  logic                  i_we,
    input  logic                  i_rd_bank,
    input  logic [AW-1:0]         iv_rd_addr,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] ov_rd_data
);

    logic [DATA_WIDTH-1:0] mem [2*WORDS];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge i_clk) begin
        if (i_we) mem[{i_wr_bank, iv_wr_addr}] <= iv_wr_data;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (i_rd_en) rd_data_d = mem[{i_rd_bank, iv_rd_addr}];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

    assign ov_rd_data = rd_data_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// Streams a coefficient set into the shadow bank and swaps banks on a filter output boundary.
// FIR_COEF_SYMMETRIC_EN: half-length sets, read addresses >= FIR_DEPTH/2 mirrored.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int FIR_DEPTH  = FIR_DEPTH_DEF,
    localparam int ADDR_WIDTH = $clog2(FIR_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] iv_coef,
    input  logic                  i_coef_valid,
    input  logic                  i_coef_last,
    output logic                  o_coef_ready,
    input  logic                  i_frame_boundary,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] iv_rd_addr,
    output logic [DATA_WIDTH-1:0] ov_rd_data,
    output logic                  o_bank_sel,
    output logic                  o_swap_pending,
    output logic                  o_swapped,
    output logic                  o_load_err
);

    localparam int SET_LEN = set_len(FIR_DEPTH);
    localparam int PTR_W   = $clog2(SET_LEN);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SET_LEN - 1);

    ld_state_e        state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             bank_sel_q, bank_sel_d;
    logic             coef_ready_q, coef_ready_d;
    logic             swap_pending_q, swap_pending_d;
    logic             swapped_q, swapped_d;
    logic             load_err_q, load_err_d;
    logic             we;
    logic             xfer;
    logic [ADDR_WIDTH-1:0] rd_addr_m;

    assign xfer = i_coef_valid && coef_ready_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        bank_sel_d = bank_sel_q;
        swapped_d  = 1'b0;
        load_err_d = 1'b0;
        we         = 1'b0;
        case (state_q)
            // IDLE behaves like LOAD so a one-word set is judged on its own.
            ST_IDLE, ST_LOAD: begin
                if (xfer) begin
                    we = 1'b1;
                    if (i_coef_last) begin
                        if (ptr_q == PTR_LAST) begin
                            state_d = ST_PENDING;
                        end else begin
                            load_err_d = 1'b1;
                            ptr_d      = '0;
                            state_d    = ST_IDLE;
                        end
                    end else if (ptr_q == PTR_LAST) begin
                        load_err_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer && i_coef_last) begin
                    ptr_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (i_frame_boundary) begin
                    bank_sel_d = ~bank_sel_q;
                    ptr_d      = '0;
                    swapped_d  = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        coef_ready_d   = (state_d != ST_PENDING);
        swap_pending_d = (state_d == ST_PENDING);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            bank_sel_q     <= 1'b0;
            coef_ready_q   <= 1'b0;
            swap_pending_q <= 1'b0;
            swapped_q      <= 1'b0;
            load_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            bank_sel_q     <= bank_sel_d;
            coef_ready_q   <= coef_ready_d;
            swap_pending_q <= swap_pending_d;
            swapped_q      <= swapped_d;
            load_err_q     <= load_err_d;
        end
    end

    always_comb begin
        rd_addr_m = iv_rd_addr;
`ifdef FIR_COEF_SYMMETRIC_EN
        if (iv_rd_addr >= ADDR_WIDTH'(FIR_DEPTH / 2))
            rd_addr_m = ADDR_WIDTH'(FIR_DEPTH - 1) - iv_rd_addr;
`endif
    end

    fir_coeff_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (SET_LEN)
    ) u_bank (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_bank  (~bank_sel_q),
        .iv_wr_addr (ptr_q),
        .iv_wr_data (iv_coef),
        .i_we       (we),
        .i_rd_bank  (bank_sel_q),
        .iv_rd_addr (rd_addr_m[PTR_W-1:0]),
        .i_rd_en    (i_rd_en),
        .ov_rd_data (ov_rd_data)
    );

    assign o_coef_ready   = coef_ready_q;
    assign o_bank_sel     = bank_sel_q;
    assign o_swap_pending = swap_pending_q;
    assign o_swapped      = swapped_q;
    assign o_load_err     = load_err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized bench for fir_coeff_loader against a per-bank coefficient model.
module tb_fir_coeff_loader;
    localparam int DW    = 24;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef FIR_COEF_SYMMETRIC_EN
    localparam int N = DEPTH / 2;
`else
    localparam int N = DEPTH;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [DW-1:0] iv_coef = '0;
    logic          i_coef_valid = 1'b0;
    logic          i_coef_last = 1'b0;
    logic          o_coef_ready;
    logic          i_frame_boundary = 1'b0;
    logic          i_rd_en = 1'b0;
    logic [AW-1:0] iv_rd_addr = '0;
    logic [DW-1:0] ov_rd_data;
    logic          o_bank_sel, o_swap_pending, o_swapped, o_load_err;

    fir_coeff_loader dut (
        .i_clk(i_clk), .i_rst(i_rst), .iv_coef(iv_coef), .i_coef_valid(i_coef_valid),
        .i_coef_last(i_coef_last), .o_coef_ready(o_coef_ready),
        .i_frame_boundary(i_frame_boundary), .i_rd_en(i_rd_en), .iv_rd_addr(iv_rd_addr),
        .ov_rd_data(ov_rd_data), .o_bank_sel(o_bank_sel), .o_swap_pending(o_swap_pending),
        .o_swapped(o_swapped), .o_load_err(o_load_err)
    );

    always #5 i_clk = ~i_clk;

    // Model: physical contents of each bank, which entries are known, and the active bank.
    logic [DW-1:0] mem   [2][DEPTH];
    bit            known [2][DEPTH];
    bit            msel;
    int            n_chk = 0, n_pass = 0, err_cnt = 0, exp_err = 0;

    always @(negedge i_clk) if (!i_rst && o_load_err === 1'b1) err_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    function automatic int phys(input int k);
        if (N < DEPTH && k >= DEPTH / 2) return DEPTH - 1 - k;
        return k;
    endfunction

    task automatic do_reset;
        i_rst = 1'b1; i_coef_valid = 1'b0; i_coef_last = 1'b0;
        i_frame_boundary = 1'b0; i_rd_en = 1'b0;
        tick; tick;
        i_rst = 1'b0;
        tick;
        msel = 1'b0;
        chk("rst_bank_sel", o_bank_sel, 0);
        chk("rst_pending", o_swap_pending, 0);
        chk("rst_ready", o_coef_ready, 1);
        chk("rst_swapped", o_swapped, 0);
        chk("rst_load_err", o_load_err, 0);
        chk("rst_rd_data", ov_rd_data, 0);
    endtask

    task automatic rd_chk(input int a);
        int p = phys(a);
        iv_rd_addr = AW'(a);
        i_rd_en = 1'b1;
        tick;
        i_rd_en = 1'b0;
        iv_rd_addr = AW'(a + 1);
        if (known[msel][p]) chk("rd_data", ov_rd_data, mem[msel][p]);
        tick;
        if (known[msel][p]) chk("rd_hold", ov_rd_data, mem[msel][p]);
    endtask

    // Stream n words with last on word n; optional boundary on the last-word cycle.
    task automatic send_set(input int n, input bit bnd_last, input bit fixed, input logic [DW-1:0] base);
        int sh = msel ? 0 : 1;
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(0, 2);
            int w = 0;
            logic [DW-1:0] d = fixed ? base + DW'(i) : DW'($urandom);
            for (int g = 0; g < gap; g++) begin
                i_coef_valid = 1'b0;
                i_frame_boundary = 1'($urandom_range(0, 1));
                tick;
            end
            i_coef_valid = 1'b1; iv_coef = d; i_coef_last = (i == n - 1);
            i_frame_boundary = (i == n - 1) ? bnd_last : 1'($urandom_range(0, 1));
            while (!o_coef_ready && w < 50) begin tick; w++; end
            if (w >= 50) chk("ready_timeout", 0, 1);
            tick;
            if (i < N) begin mem[sh][i] = d; known[sh][i] = 1'b1; end
            if (n > N && i == N - 1) begin chk("overrun_err", o_load_err, 1); exp_err++; end
        end
        i_coef_valid = 1'b0; i_coef_last = 1'b0; i_frame_boundary = 1'b0;
        if (n == N) begin
            chk("good_no_err", o_load_err, 0);
            chk("good_pending", o_swap_pending, 1);
            chk("good_not_ready", o_coef_ready, 0);
        end else begin
            if (n < N) begin chk("short_err", o_load_err, 1); exp_err++; end
            else chk("drain_end_no_err", o_load_err, 0);
            chk("bad_no_pending", o_swap_pending, 0);
            chk("bad_ready", o_coef_ready, 1);
        end
    endtask

    task automatic wait_idle(input int cyc);
        for (int c = 0; c < cyc; c++) begin
            tick;
            chk("hold_pending", o_swap_pending, 1);
            chk("hold_bank", o_bank_sel, msel);
        end
    endtask

    // Boundary while pending; optionally read in the swap cycle (must see the old bank).
    task automatic do_swap(input bit rd, input int a);
        int p = phys(a);
        bit old = msel;
        i_frame_boundary = 1'b1;
        if (rd) begin iv_rd_addr = AW'(a); i_rd_en = 1'b1; end
        tick;
        i_frame_boundary = 1'b0; i_rd_en = 1'b0;
        msel = ~msel;
        chk("swap_bank", o_bank_sel, msel);
        chk("swap_pulse", o_swapped, 1);
        chk("swap_clr_pending", o_swap_pending, 0);
        if (rd && known[old][p]) chk("swap_cycle_old", ov_rd_data, mem[old][p]);
        tick;
        chk("swap_pulse_end", o_swapped, 0);
    endtask

    task automatic idle_boundary;
        i_frame_boundary = 1'b1;
        tick;
        i_frame_boundary = 1'b0;
        chk("no_swap_bank", o_bank_sel, msel);
        tick;
        chk("no_swap_pulse", o_swapped, 0);
    endtask

    initial begin
        foreach (known[b, k]) known[b][k] = 1'b0;
        msel = 1'b0;
        do_reset;
        for (int a = 0; a < DEPTH; a++) rd_chk(a);
        chk("idle_bank", o_bank_sel, 0);

        // Directed known set, boundary 5 cycles later.
        send_set(N, 1'b0, 1'b1, 24'h000100);
        wait_idle(5);
        do_swap(1'b0, 0);
        rd_chk(3);
        for (int a = 0; a < DEPTH; a++) rd_chk(a);

        // Short set: error, no swap, old data remains.
        send_set(N / 2, 1'b0, 1'b0, '0);
        idle_boundary;
        for (int a = 0; a < 4; a++) rd_chk($urandom_range(0, DEPTH - 1));

        // Overlong set: error at word N, drained, then a good set swaps.
        send_set(N + 4, 1'b0, 1'b0, '0);
        idle_boundary;
        send_set(N, 1'b0, 1'b0, '0);
        do_swap(1'b0, 0);
        for (int a = 0; a < DEPTH; a++) rd_chk(a);

        // Boundary coinciding with last word is ignored; next boundary swaps.
        send_set(N, 1'b1, 1'b0, '0);
        wait_idle(2);
        do_swap(1'b1, 5);
        rd_chk(5);

        // Reset while pending: bank 0 active with its latest contents.
        send_set(N, 1'b0, 1'b0, '0);
        do_reset;
        for (int a = 0; a < DEPTH; a++) rd_chk(a);

        // Randomized mix.
        for (int it = 0; it < 12; it++) begin
            int kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                send_set(N, 1'($urandom_range(0, 1)), 1'b0, '0);
                wait_idle($urandom_range(0, 4));
                rd_chk($urandom_range(0, DEPTH - 1));
                do_swap(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1));
            end else if (kind == 2) begin
                send_set($urandom_range(1, N - 1), 1'b0, 1'b0, '0);
            end else begin
                send_set($urandom_range(N + 1, N + 6), 1'b0, 1'b0, '0);
            end
            for (int r = 0; r < 3; r++) rd_chk($urandom_range(0, DEPTH - 1));
        end

        tick;
        chk("err_pulse_count", err_cnt, exp_err);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
